aer_event_scheduler: RTL and testbench

Sequencing controller for the AER event packer. It arbitrates pending pixel requests from a ROWS×COLS array using row-then-column round-robin. It timestamps the winning event with a free-running counter and presents the packed event word {timestamp, x, y, polarity} on a valid/ready output. It acknowledges the granted pixel, and it sits between the pixel request matrix and the downstream event FIFO/readout.

---
 rtl/aer_event_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_aer_event_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_event_scheduler.sv
// AER event scheduler: row-then-column round-robin arbitration of pixel requests,
// timestamping, and valid/ready event output. Optional macro AER_TS_WRAP_EN adds ts_wrap_o.
module aer_event_scheduler #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int ROW_ADD = $clog2(ROWS),
    parameter int COL_ADD = $clog2(COLS),
    parameter int SIZE    = 24,
    parameter int WIDTH   = SIZE + ROW_ADD + COL_ADD + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [ROWS*COLS-1:0] req_i,
    input  logic [ROWS*COLS-1:0] pol_i,
    input  logic                 evt_ready_i,
    output logic                 evt_valid_o,
    output logic [WIDTH-1:0]     evt_data_o,
    output logic [ROWS*COLS-1:0] ack_o,
    output logic                 busy_o
`ifdef AER_TS_WRAP_EN
    ,
    output logic                 ts_wrap_o
`endif
);

    localparam int PIX = ROWS * COLS;
    localparam logic [PIX-1:0] PIX_ONE = {{(PIX-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROW_SEL = 3'd1,
        COL_SEL = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4
    } state_t;

    state_t               state_r, state_next_s;
    logic [SIZE-1:0]      ts_r, ts_q_r;
    logic [ROW_ADD-1:0]   row_ptr_r, row_sel_r, row_idx_s;
    logic [COL_ADD-1:0]   col_ptr_r, col_sel_r, col_idx_s;
    logic                 row_hit_s, col_hit_s, pol_sel_s;
    logic                 evt_valid_r, busy_r;
    logic [WIDTH-1:0]     evt_data_r;
    logic [PIX-1:0]       ack_r;
    int                   pix_s, ack_pix_s;

    // Returns {hit, row}: first row at or after ptr (wrapping) with any request.
    function automatic logic [ROW_ADD:0] find_row(input logic [PIX-1:0] req,
                                                  input logic [ROW_ADD-1:0] ptr);
        logic               hit;
        logic [ROW_ADD-1:0] idx;
        int                 cand;
        hit = 1'b0;
        idx = {ROW_ADD{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            cand = (int'(ptr) + i) % ROWS;
            if (!hit && (req[cand*COLS +: COLS] != {COLS{1'b0}})) begin
                hit = 1'b1;
                idx = ROW_ADD'(cand);
            end
        end
        return {hit, idx};
    endfunction

    // Returns {hit, col}: first set column at or after ptr (wrapping).
    function automatic logic [COL_ADD:0] find_col(input logic [COLS-1:0] bits,
                                                  input logic [COL_ADD-1:0] ptr);
        logic               hit;
        logic [COL_ADD-1:0] idx;
        int                 cand;
        hit = 1'b0;
        idx = {COL_ADD{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            cand = (int'(ptr) + i) % COLS;
            if (!hit && bits[cand]) begin
                hit = 1'b1;
                idx = COL_ADD'(cand);
            end
        end
        return {hit, idx};
    endfunction

    // Arbitration search against the live request matrix.
    always_comb begin
        {row_hit_s, row_idx_s} = find_row(req_i, row_ptr_r);
        {col_hit_s, col_idx_s} = find_col(req_i[int'(row_sel_r)*COLS +: COLS], col_ptr_r);
        pix_s     = int'(row_sel_r) * COLS + int'(col_idx_s);
        ack_pix_s = int'(row_sel_r) * COLS + int'(col_sel_r);
        pol_sel_s = pol_i[pix_s];
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (|req_i)      state_next_s = ROW_SEL; else state_next_s = IDLE;
            ROW_SEL: if (row_hit_s)   state_next_s = COL_SEL; else state_next_s = IDLE;
            COL_SEL: if (col_hit_s)   state_next_s = SEND;    else state_next_s = IDLE;
            SEND:    if (evt_ready_i) state_next_s = ACK;     else state_next_s = SEND;
            ACK:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_r <= IDLE;
        else          state_r <= state_next_s;
    end

    // Free-running timestamp; never stalls.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ts_r <= {SIZE{1'b0}};
        else          ts_r <= ts_r + SIZE'(1);
    end

    // Event datapath, grant pulse and round-robin pointers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_q_r      <= {SIZE{1'b0}};
            row_ptr_r   <= {ROW_ADD{1'b0}};
            col_ptr_r   <= {COL_ADD{1'b0}};
            row_sel_r   <= {ROW_ADD{1'b0}};
            col_sel_r   <= {COL_ADD{1'b0}};
            evt_valid_r <= 1'b0;
            evt_data_r  <= {WIDTH{1'b0}};
            ack_r       <= {PIX{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    ack_r <= {PIX{1'b0}};
                    if (|req_i) ts_q_r <= ts_r;
                end
                ROW_SEL: row_sel_r <= row_idx_s;
                COL_SEL: begin
                    if (col_hit_s) begin
                        col_sel_r   <= col_idx_s;
                        evt_data_r  <= {ts_q_r, row_sel_r, col_idx_s, pol_sel_s};
                        evt_valid_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (evt_ready_i) begin
                        evt_valid_r <= 1'b0;
                        ack_r       <= PIX_ONE << ack_pix_s;
                    end
                end
                ACK: begin
                    // One-cycle grant; pointers move past the winner.
                    ack_r     <= {PIX{1'b0}};
                    row_ptr_r <= (row_sel_r == ROW_ADD'(ROWS-1)) ? {ROW_ADD{1'b0}}
                                                                 : row_sel_r + ROW_ADD'(1);
                    col_ptr_r <= (col_sel_r == COL_ADD'(COLS-1)) ? {COL_ADD{1'b0}}
                                                                 : col_sel_r + COL_ADD'(1);
                end
                default: ack_r <= {PIX{1'b0}};
            endcase
        end
    end

`ifdef AER_TS_WRAP_EN
    logic wrap_r;

    // Flags the cycle where ts reads zero because it rolled over, not because of reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) wrap_r <= 1'b0;
        else          wrap_r <= (ts_r == {SIZE{1'b1}});
    end

    assign ts_wrap_o = wrap_r;
`endif

    assign evt_valid_o = evt_valid_r;
    assign evt_data_o  = evt_data_r;
    assign ack_o       = ack_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_aer_event_scheduler.sv
// Scoreboard bench for aer_event_scheduler: randomized pixel requests checked against
// a round-robin reference model; timestamp width reduced so wrap is exercised.
module tb_aer_event_scheduler;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int RA   = 3;
    localparam int CA   = 3;
    localparam int SIZE = 4;
    localparam int W    = SIZE + RA + CA + 1;
    localparam int N    = ROWS * COLS;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] pol   = '0;
    logic         ready = 1'b0;
    logic         valid, busy;
    logic [W-1:0] data;
    logic [N-1:0] ack;
`ifdef AER_TS_WRAP_EN
    logic         ts_wrap;
`endif

    always #5 clk = ~clk;

    aer_event_scheduler #(.ROWS(ROWS), .COLS(COLS), .SIZE(SIZE)) dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .req_i      (req),
        .pol_i      (pol),
        .evt_ready_i(ready),
        .evt_valid_o(valid),
        .evt_data_o (data),
        .ack_o      (ack),
        .busy_o     (busy)
`ifdef AER_TS_WRAP_EN
        ,
        .ts_wrap_o  (ts_wrap)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] onehot;
        int           hs;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           tcount;
    int           rp = 0;
    int           cp = 0;
    logic [N-1:0] ack_exp = '0;

    // Reference cycle count since reset release; equals the DUT timestamp modulo 2^SIZE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcount <= 0;
        else        tcount <= tcount + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares presented events against the scoreboard and checks grant pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_exp = '0;
        end else begin
            check("ack", ack, ack_exp);
            ack_exp = '0;
`ifdef AER_TS_WRAP_EN
            check("ts_wrap", ts_wrap, (tcount > 0 && tcount % (1 << SIZE) == 0));
`endif
            if (valid) begin
                check("busy_in_send", busy, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got data %0h expected none", data);
                end else begin
                    check("evt_data", data, exp_q[0].data);
                    if (ready) begin
                        check("handshake_cycle", tcount, exp_q[0].hs);
                        ack_exp = exp_q[0].onehot;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Winner by the arbitration rule: first busy row from rp, then first request in it from cp.
    function automatic void pick(input logic [N-1:0] p, output int r, output int c);
        int rr, cc;
        r = -1;
        c = -1;
        for (int i = 0; i < ROWS; i++) begin
            rr = (rp + i) % ROWS;
            if (r < 0 && p[rr*COLS +: COLS] != '0) r = rr;
        end
        for (int j = 0; j < COLS; j++) begin
            cc = (cp + j) % COLS;
            if (r >= 0 && c < 0 && p[r*COLS + cc]) c = cc;
        end
    endfunction

    function automatic exp_t expect_evt(input logic [N-1:0] p, input logic [N-1:0] pl, input int hs);
        exp_t e;
        int   r, c;
        pick(p, r, c);
        e.data   = W'((tcount % (1 << SIZE)) * (1 << (RA + CA + 1)) + r * (1 << (CA + 1))
                      + c * 2 + int'(pl[r*COLS + c]));
        e.onehot = '0;
        e.onehot[r*COLS + c] = 1'b1;
        e.hs     = tcount + hs;
        rp       = (r + 1) % ROWS;
        cp       = (c + 1) % COLS;
        return e;
    endfunction

    // One event: requests held until latched, scrambled during SEND, dropped in the ack cycle.
    task automatic run_txn(input logic [N-1:0] p, input logic [N-1:0] pl, input int stall, input int gap);
        int hs;
        hs = (stall > 3) ? stall : 3;
        exp_q.push_back(expect_evt(p, pl, hs));
        req   = p;
        pol   = pl;
        ready = (stall == 0);
        for (int i = 1; i <= hs + 1; i++) begin
            @(posedge clk); #1;
            if (i >= 3 && i <= hs) begin
                req = {$urandom, $urandom};
                pol = {$urandom, $urandom};
            end
            if (i >= stall) ready = 1'b1;
            if (i == hs + 1) begin
                req   = '0;
                ready = 1'b0;
            end
        end
        repeat (gap) begin @(posedge clk); #1; end
        check("event_taken", exp_q.size(), 0);
    endtask

    // Request seen in IDLE but withdrawn before a column is chosen: no event.
    task automatic withdraw(input logic [N-1:0] p, input int at);
        req = p;
        pol = {$urandom, $urandom};
        repeat (at) begin @(posedge clk); #1; end
        req = '0;
        repeat (4) begin @(posedge clk); #1; end
        check("busy_after_withdraw", busy, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [N-1:0] rand_pat();
        logic [N-1:0] p;
        int           nb;
        p  = '0;
        nb = $urandom_range(1, 4);
        repeat (nb) p[$urandom_range(0, N-1)] = 1'b1;
        return p;
    endfunction

    initial begin
        logic [N-1:0] p, pl, bit10, rows03, cols2;
        #3;
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
`ifdef AER_TS_WRAP_EN
        check("rst_wrap", ts_wrap, 0);
`endif
        release_reset();

        // Single pixel (1,2) at ts=5.
        bit10 = '0;
        bit10[10] = 1'b1;
        while (tcount != 5) begin @(posedge clk); #1; end
        run_txn(bit10, bit10, 0, 4);

        // Row round-robin with rows 0 and 3 re-requesting.
        rows03 = '0;
        rows03[0*COLS + 4] = 1'b1;
        rows03[3*COLS + 4] = 1'b1;
        repeat (4) run_txn(rows03, {$urandom, $urandom}, 0, 1);

        // Column fairness from fresh pointers.
        rst_n = 1'b0;
        rp = 0;
        cp = 0;
        release_reset();
        cols2 = '0;
        cols2[2*COLS + 1] = 1'b1;
        cols2[2*COLS + 6] = 1'b1;
        repeat (2) run_txn(cols2, {$urandom, $urandom}, 0, 1);

        // Backpressure in SEND while inputs churn.
        run_txn(rand_pat(), {$urandom, $urandom}, 13, 2);

        withdraw(rand_pat(), 1);
        withdraw(rand_pat(), 2);

        for (int k = 0; k < 40; k++) begin
            if (k == 0 || $urandom_range(0, 3) != 0) p = rand_pat();
            pl = {$urandom, $urandom};
            run_txn(p, pl, $urandom_range(0, 6), $urandom_range(1, 3));
        end

        // Asynchronous reset in the middle of SEND drops the event.
        p = rand_pat();
        exp_q.push_back(expect_evt(p, '0, 100));
        req   = p;
        pol   = '0;
        ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_ack", ack, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        req = '0;
        rp  = 0;
        cp  = 0;
        release_reset();
        run_txn(rand_pat(), {$urandom, $urandom}, 0, 3);

        // Event requested at ts=15 keeps timestamp 15 across the wrap.
        while (tcount % (1 << SIZE) != 15) begin @(posedge clk); #1; end
        run_txn(rand_pat(), {$urandom, $urandom}, 2, 3);

        repeat (20) begin @(posedge clk); #1; end
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
